// File: rtl/zigbee_pkg.sv
// Shared types and defaults for the 802.15.4 TX datapath.
package zigbee_pkg;

  // Default word and symbol widths (one 802.15.4 symbol is 4 bits).
  localparam int unsigned ZB_WORD_W = 32;
  localparam int unsigned ZB_SYM_W  = 4;

  // Serializer control states.
  typedef enum logic [0:0] {
    StIdle,
    StShift
  } ser_state_e;

endpackage

// File: rtl/symbol_slice_mux.sv
// N_SYM:1 mux picking one SYM_W-bit slice out of a DATA_W-bit word.
module symbol_slice_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SYM_W  = 4,
  localparam int unsigned N_SYM = DATA_W / SYM_W,
  localparam int unsigned CNT_W = (N_SYM > 1) ? $clog2(N_SYM) : 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  sel_i,
  output logic [SYM_W-1:0]  sym_o
);

  logic [N_SYM-1:0][SYM_W-1:0] slices;

  assign slices = data_i;

  // Select slice sel_i; out-of-range selects (non power-of-two N_SYM) give zero.
  always_comb begin
    sym_o = '0;
    for (int unsigned i = 0; i < N_SYM; i++) begin
      if (sel_i == CNT_W'(i)) begin
        sym_o = slices[i];
      end
    end
  end

endmodule

// File: rtl/symbol_serializer.sv
// Word-to-symbol serializer: takes one DATA_W word per valid/ready handshake and
// emits DATA_W/SYM_W symbols, LSB- or MSB-first, one per downstream handshake.
// outReady in StShift depends combinationally on inSymReady (and on inFlush in
// every state); all other outputs come from registered state only.
module symbol_serializer
  import zigbee_pkg::*;
#(
  parameter int unsigned DATA_W = ZB_WORD_W,
  parameter int unsigned SYM_W  = ZB_SYM_W,
  localparam int unsigned N_SYM = DATA_W / SYM_W,
  localparam int unsigned CNT_W = (N_SYM > 1) ? $clog2(N_SYM) : 1
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic [DATA_W-1:0] inData,
  input  logic              inMsbFirst,
  input  logic              inValid,
  output logic              outReady,
  input  logic              inFlush,
  output logic [SYM_W-1:0]  outSym,
  output logic              outSymValid,
  input  logic              inSymReady,
  output logic              outLast,
  output logic [CNT_W-1:0]  outSymIdx
);

  if (((DATA_W % SYM_W) != 0) || (N_SYM < 2)) begin : g_bad_params
    $error("symbol_serializer: DATA_W must be a multiple of SYM_W with N_SYM >= 2");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(N_SYM - 1);

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              msb_q, msb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Holds outReady low until the first clock edge after reset release.
  logic              ready_en_q;

  logic              in_shift;
  logic              is_last;
  logic              sym_hs;
  logic              load;
  logic [CNT_W-1:0]  slice_sel;
  logic [SYM_W-1:0]  slice_sym;

  assign in_shift = (state_q == StShift);
  assign is_last  = in_shift && (cnt_q == CntLast);
  assign sym_hs   = in_shift && inSymReady;

  // Accept a word when idle, or on the last symbol handshake for zero-bubble streaming.
  always_comb begin
    outReady = 1'b0;
    if (ready_en_q && !inFlush) begin
      outReady = !in_shift || (is_last && inSymReady);
    end
  end

  assign load = inValid && outReady;

  // Next-state: flush beats load and symbol handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    msb_d   = msb_q;
    cnt_d   = cnt_q;
    if (inFlush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            data_d  = inData;
            msb_d   = inMsbFirst;
            cnt_d   = '0;
            state_d = StShift;
          end
        end
        StShift: begin
          if (sym_hs) begin
            if (is_last) begin
              cnt_d = '0;
              if (load) begin
                data_d = inData;
                msb_d  = inMsbFirst;
              end else begin
                state_d = StIdle;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, word, order and counter registers.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q    <= StIdle;
      data_q     <= '0;
      msb_q      <= 1'b0;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      msb_q      <= msb_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  // Emission index to slice index: reversed for MSB-first words.
  assign slice_sel = msb_q ? (CntLast - cnt_q) : cnt_q;

  symbol_slice_mux #(
    .DATA_W (DATA_W),
    .SYM_W  (SYM_W)
  ) u_slice_mux (
    .data_i (data_q),
    .sel_i  (slice_sel),
    .sym_o  (slice_sym)
  );

  assign outSymValid = in_shift;
  assign outSym      = in_shift ? slice_sym : '0;
  assign outLast     = is_last;
  assign outSymIdx   = cnt_q;

endmodule

// File: tb/tb_symbol_serializer.sv
// Self-checking bench for symbol_serializer: table of words, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_symbol_serializer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SYM_W  = 4;
  localparam int unsigned N_SYM  = DATA_W / SYM_W;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_msb = 1'b0;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic              sym_ready = 1'b0;
  logic              out_ready;
  logic [SYM_W-1:0]  sym;
  logic              sym_valid;
  logic              last;
  logic [CNT_W-1:0]  idx;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] word;
    logic        msb;
    logic [31:0] exp_seq;  // emission order read left to right, one hex digit per symbol
  } vec_t;

  vec_t table_v[5];

  always #5 clk = ~clk;

  symbol_serializer #(
    .DATA_W (DATA_W),
    .SYM_W  (SYM_W)
  ) dut (
    .inClk       (clk),
    .inRstN      (rst_n),
    .inData      (in_data),
    .inMsbFirst  (in_msb),
    .inValid     (in_valid),
    .outReady    (out_ready),
    .inFlush     (flush),
    .outSym      (sym),
    .outSymValid (sym_valid),
    .inSymReady  (sym_ready),
    .outLast     (last),
    .outSymIdx   (idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] s,
                           input int i, input logic l, input logic r);
    check({tag, ".valid"}, 32'(sym_valid), 32'(v));
    check({tag, ".sym"},   32'(sym), 32'(s));
    check({tag, ".idx"},   32'(idx), 32'(i));
    check({tag, ".last"},  32'(last), 32'(l));
    check({tag, ".ready"}, 32'(out_ready), 32'(r));
  endtask

  // Inputs change at edge+1, outputs are sampled at edge+3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one word with sym_ready held high and check every emitted symbol.
  task automatic run_word(input string tag, input logic [31:0] w, input logic m,
                          input logic [31:0] exp_seq);
    in_data = w; in_msb = m; in_valid = 1'b1; sym_ready = 1'b1;
    #2 check({tag, ".accept_ready"}, 32'(out_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_data = 32'hFFFF_FFFF; in_msb = ~m;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e;
      e = exp_seq[4*(7-k) +: 4];
      #2 check_out(tag, 1'b1, e, k, k == 7, k == 7);
      tick();
    end
    #2 check_out({tag, ".idle"}, 1'b0, 4'h0, 0, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    logic [3:0] q[$];
    int pos;

    table_v[0] = '{32'h7654_3210, 1'b0, 32'h0123_4567};
    table_v[1] = '{32'h7654_3210, 1'b1, 32'h7654_3210};
    table_v[2] = '{32'hA5A5_A5A5, 1'b0, 32'h5A5A_5A5A};
    table_v[3] = '{32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    table_v[4] = '{32'hDEAD_BEEF, 1'b0, 32'hFEEB_DAED};

    // Reset held across the first edge.
    #12 check_out("reset", 1'b0, 4'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", 32'(out_ready), 32'd0);
    tick();
    #2 check_out("after_release", 1'b0, 4'h0, 0, 1'b0, 1'b1);
    tick();

    for (int t = 0; t < 5; t++) begin
      run_word($sformatf("table%0d", t), table_v[t].word, table_v[t].msb, table_v[t].exp_seq);
    end

    // Backpressure: ready pattern 1,0,0,1 repeating.
    in_data = 32'h7654_3210; in_msb = 1'b0; in_valid = 1'b1; sym_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    pos = 0;
    for (int c = 0; c < 40 && pos < 8; c++) begin
      sym_ready = ((c % 4) == 0) || ((c % 4) == 3);
      #2 check_out("bp", 1'b1, 4'(pos), pos, pos == 7, (pos == 7) && sym_ready);
      if (sym_ready) pos++;
      tick();
    end
    check("bp_all_delivered", 32'(pos), 32'd8);
    sym_ready = 1'b1;
    #2 check_out("bp_idle", 1'b0, 4'h0, 0, 1'b0, 1'b1);
    tick();

    // Back-to-back words with inValid held: 16 symbols, no gap.
    in_data = 32'h7654_3210; in_msb = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'hFEDC_BA98;
    for (int k = 0; k < 16; k++) begin
      #2 check_out("b2b", 1'b1, 4'(k), k % 8, (k % 8) == 7, (k % 8) == 7);
      tick();
      if (k == 7) in_valid = 1'b0;
    end
    #2 check_out("b2b_idle", 1'b0, 4'h0, 0, 1'b0, 1'b1);
    tick();

    // Flush at idx 3 while a new word is offered.
    in_data = 32'h7654_3210; in_msb = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h1111_1111;
    #2 check_out("flush_cycle", 1'b1, 4'h3, 3, 1'b0, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #2 check_out("flush_after", 1'b0, 4'h0, 0, 1'b0, 1'b1);
    tick();
    #2 check_out("flush_not_loaded", 1'b0, 4'h0, 0, 1'b0, 1'b1);
    tick();

    // Asynchronous reset in the middle of a word.
    in_data = 32'h7654_3210; in_msb = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2 check("pre_reset_idx", 32'(idx), 32'd5);
    #1 rst_n = 1'b0;
    #1 check_out("async_reset", 1'b0, 4'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    tick();
    run_word("post_reset", 32'hA5A5_A5A5, 1'b0, 32'h5A5A_5A5A);

    // Randomized traffic against a queue model of pending symbols.
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic exp_ready;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      in_msb    = 1'($urandom_range(0, 1));
      sym_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      exp_ready = !flush && ((q.size() == 0) || ((q.size() == 1) && sym_ready));
      #2;
      if (q.size() > 0)
        check_out("rand", 1'b1, q[0], N_SYM - q.size(), q.size() == 1, exp_ready);
      else
        check_out("rand", 1'b0, 4'h0, 0, 1'b0, exp_ready);
      if (flush) begin
        q.delete();
      end else begin
        if ((q.size() > 0) && sym_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          for (int s = 0; s < 8; s++) begin
            int slice;
            slice = in_msb ? (7 - s) : s;
            q.push_back(4'((in_data >> (4 * slice)) & 32'hF));
          end
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
